// File: rtl/uart_tx_fifo_if.sv
// IO bus between the core's memory stage and the UART transmitter peripheral.
// The core drives address, data and write strobe; the peripheral returns
// a combinational status word on the read-data lines.
interface uart_tx_fifo_if;
   logic [31:0] IO_mem_addr;
   logic [31:0] IO_mem_wdata;
   logic        IO_mem_wr;
   logic [31:0] IO_mem_rdata;

   modport master (
      output IO_mem_addr,
      output IO_mem_wdata,
      output IO_mem_wr,
      input  IO_mem_rdata
   );

   modport slave (
      input  IO_mem_addr,
      input  IO_mem_wdata,
      input  IO_mem_wr,
      output IO_mem_rdata
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// Memory-mapped UART transmitter: decodes IO writes to the data word,
// buffers bytes in a circular FIFO and shifts them out 8N1, LSB first.
// The status word (overflow, busy, full) is returned combinationally so
// firmware can poll before storing the next byte.
module uart_tx_fifo #(
   parameter int CLK_FREQ_HZ = 27_000_000,
   parameter int BAUD        = 115200,
   parameter int DEPTH       = 16
) (
   input  logic          clk,
   input  logic          RESET,
   uart_tx_fifo_if.slave io,
   output logic          uart_tx,
   output logic          tx_busy
);

   // Cycles per line bit; truncating division, never below one cycle.
   localparam int DIV_RAW = CLK_FREQ_HZ / BAUD;
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int AW      = $clog2(DEPTH);
   localparam int CW      = AW + 1;

   localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);
   localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);

   // Elaboration guard: the pointer arithmetic relies on natural wrap.
   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_e;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_e            state_q;
   logic [CNT_W-1:0]  baud_cnt_q;
   logic [2:0]        bit_idx_q;
   logic [7:0]        shifter_q;
   logic              uart_tx_q;
   logic              tx_busy_q;
   logic              overflow_q;

   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [CW-1:0]     count_q;
   logic [CW-1:0]     count_d;
   logic [7:0]        mem_q [DEPTH];

   // ------------------------------------------------------------------
   // Bus decode
   // ------------------------------------------------------------------
   logic sel;
   logic full;
   logic push;
   logic drop;
   logic clr_ovf;
   logic pop;
   logic bit_done;
   logic fifo_nonempty;
   logic fsm_idle_d;
   logic [7:0] head;

   // Only word-address bit 1 selects the data word; the rest is ignored.
   logic unused_bus_bits;
   assign unused_bus_bits = ^{io.IO_mem_addr[31:4], io.IO_mem_addr[2:0],
                              io.IO_mem_wdata[30:8]};

   assign sel           = io.IO_mem_addr[3];
   assign full          = (count_q == DEPTH_C);
   assign fifo_nonempty = (count_q != '0);
   assign bit_done      = (baud_cnt_q == '0);
   assign head          = mem_q[rd_ptr_q];

   // Classify a selected write as flag clear, accepted byte or dropped byte.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      push    = 1'b0;
      drop    = 1'b0;
      clr_ovf = 1'b0;
      if (io.IO_mem_wr && sel) begin
         if (io.IO_mem_wdata[31]) begin
            clr_ovf = 1'b1;
         end else if (full) begin
            drop = 1'b1;
         end else begin
            push = 1'b1;
         end
      end
   end

   // The FSM takes a byte when idle, or at the end of a stop bit so that
   // back-to-back frames have no idle gap.
   assign pop = fifo_nonempty &&
                ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_done));

   // FSM ends up in IDLE after this edge when it has nothing to start.
   assign fsm_idle_d = !pop &&
                       ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_done));

   // A same-cycle push and pop cancel out in the occupancy count.
   assign count_d = count_q + CW'(push) - CW'(pop);

   // ------------------------------------------------------------------
   // FIFO bookkeeping and sticky overflow flag
   // ------------------------------------------------------------------
   // Pointers, occupancy and overflow flag.
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         count_q <= count_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         if (clr_ovf) begin
            overflow_q <= 1'b0;
         end else if (drop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Byte storage; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset; reset empties the FIFO through the pointers instead.
      if (push) begin
         mem_q[wr_ptr_q] <= io.IO_mem_wdata[7:0];
      end
   end

   // ------------------------------------------------------------------
   // Transmit FSM with registered line and busy outputs
   // ------------------------------------------------------------------
   // Frame sequencing, baud timing and the registered serial outputs.
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         state_q    <= S_IDLE;
         baud_cnt_q <= '0;
         bit_idx_q  <= '0;
         shifter_q  <= '0;
         uart_tx_q  <= 1'b1;
         tx_busy_q  <= 1'b0;
      end else begin
         tx_busy_q <= (count_d != '0) || !fsm_idle_d;

         unique case (state_q)
            S_IDLE: begin
               uart_tx_q <= 1'b1;
               if (pop) begin
                  shifter_q  <= head;
                  baud_cnt_q <= DIV_M1;
                  uart_tx_q  <= 1'b0;
                  state_q    <= S_START;
               end
            end

            S_START: begin
               if (bit_done) begin
                  baud_cnt_q <= DIV_M1;
                  bit_idx_q  <= '0;
                  uart_tx_q  <= shifter_q[0];
                  state_q    <= S_DATA;
               end else begin
                  baud_cnt_q <= baud_cnt_q - CNT_W'(1);
               end
            end

            S_DATA: begin
               if (bit_done) begin
                  baud_cnt_q <= DIV_M1;
                  if (bit_idx_q == 3'd7) begin
                     uart_tx_q <= 1'b1;
                     state_q   <= S_STOP;
                  end else begin
                     shifter_q <= shifter_q >> 1;
                     bit_idx_q <= bit_idx_q + 3'd1;
                     uart_tx_q <= shifter_q[1];
                  end
               end else begin
                  baud_cnt_q <= baud_cnt_q - CNT_W'(1);
               end
            end

            S_STOP: begin
               if (bit_done) begin
                  if (pop) begin
                     shifter_q  <= head;
                     baud_cnt_q <= DIV_M1;
                     uart_tx_q  <= 1'b0;
                     state_q    <= S_START;
                  end else begin
                     uart_tx_q <= 1'b1;
                     state_q   <= S_IDLE;
                  end
               end else begin
                  baud_cnt_q <= baud_cnt_q - CNT_W'(1);
               end
            end

            default: begin
               uart_tx_q <= 1'b1;
               state_q   <= S_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign uart_tx = uart_tx_q;
   assign tx_busy = tx_busy_q;

   // Bit 9 is busy, matching the firmware putchar poll loop.
   assign io.IO_mem_rdata = sel ? {21'b0, overflow_q, tx_busy_q, full, 8'b0} : 32'b0;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed frame sequences, a
// vector table for the full/overflow/decode corner, and randomized bus
// traffic compared every cycle against a frame-level reference model.
module tb_uart_tx_fifo;
   localparam int CLK_FREQ_HZ = 1000;
   localparam int BAUD        = 250;
   localparam int DEPTH       = 4;
   localparam int DIV         = 4;            // 1000 / 250
   localparam int FRAME       = 10 * DIV;
   localparam logic [31:0] A_DATA  = 32'h0040_0008;
   localparam logic [31:0] A_OTHER = 32'h0040_0004;

   logic clk = 1'b0;
   logic RESET;
   logic uart_tx;
   logic tx_busy;

   uart_tx_fifo_if bus ();

   uart_tx_fifo #(
      .CLK_FREQ_HZ(CLK_FREQ_HZ),
      .BAUD       (BAUD),
      .DEPTH      (DEPTH)
   ) dut (
      .clk    (clk),
      .RESET  (RESET),
      .io     (bus),
      .uart_tx(uart_tx),
      .tx_busy(tx_busy)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int edge_cnt = 0;
   bit line_hist [int];
   bit busy_hist [int];
   logic [7:0] scan_q[$];
   logic [7:0] exp_q[$];

   // Reference model: pending bytes, the frame on the wire, overflow flag.
   logic [7:0] m_fifo[$];
   logic [7:0] m_accepted[$];
   bit         m_active;
   int         m_start;
   logic [7:0] m_byte;
   bit         m_ovf;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      bit          exp_tx;
   } vec_t;
   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edge_cnt, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_fifo.delete();
      m_active = 1'b0;
      m_ovf    = 1'b0;
   endfunction

   // One clock edge: a frame lasts FRAME cycles from its pop; the next byte
   // may leave when the line is free; writes see the pre-edge occupancy.
   function automatic void model_edge(input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
      int pre     = m_fifo.size();
      bit can_pop = !m_active || (edge_cnt >= m_start + FRAME);
      if (can_pop && pre > 0) begin
         m_byte   = m_fifo.pop_front();
         m_active = 1'b1;
         m_start  = edge_cnt;
      end else if (can_pop) begin
         m_active = 1'b0;
      end
      if (wr && addr[3]) begin
         if (wdata[31]) begin
            m_ovf = 1'b0;
         end else if (pre < DEPTH) begin
            m_fifo.push_back(wdata[7:0]);
            m_accepted.push_back(wdata[7:0]);
         end else begin
            m_ovf = 1'b1;
         end
      end
   endfunction

   function automatic bit m_busy();
      return (m_fifo.size() > 0) || m_active;
   endfunction

   function automatic bit m_line();
      int slot;
      if (!m_active) return 1'b1;
      slot = (edge_cnt - m_start) / DIV;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return m_byte[slot-1];
      return 1'b1;
   endfunction

   function automatic logic [31:0] m_status(input logic [31:0] addr);
      if (!addr[3]) return 32'h0;
      return {21'b0, m_ovf, m_busy(), (m_fifo.size() == DEPTH), 8'b0};
   endfunction

   // Drive one bus cycle, advance the model at the edge, compare just after.
   task automatic step(input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
      bus.IO_mem_wr    = wr;
      bus.IO_mem_addr  = addr;
      bus.IO_mem_wdata = wdata;
      @(posedge clk);
      model_edge(wr, addr, wdata);
      #1;
      line_hist[edge_cnt] = uart_tx;
      busy_hist[edge_cnt] = tx_busy;
      check("line", uart_tx, m_line());
      check("busy", tx_busy, m_busy());
      check("status", bus.IO_mem_rdata, m_status(addr));
      edge_cnt++;
      bus.IO_mem_wr = 1'b0;
   endtask

   task automatic drain();
      int budget = 0;
      while ((tx_busy === 1'b1 || m_busy()) && budget < 2000) begin
         step(1'b0, A_DATA, 32'h0);
         budget++;
      end
      check("drain_bound", (budget < 2000), 1);
   endtask

   // Verify one frame whose start bit begins at cycle s.
   task automatic check_frame(input string name, input int s, input logic [7:0] exp);
      bit start_ok = 1'b1;
      bit stop_ok  = 1'b1;
      bit stable   = 1'b1;
      logic [7:0] got;
      for (int c = 0; c < DIV; c++) begin
         if (line_hist[s+c] != 1'b0) start_ok = 1'b0;
         if (line_hist[s+9*DIV+c] != 1'b1) stop_ok = 1'b0;
      end
      for (int b = 0; b < 8; b++) begin
         got[b] = line_hist[s+(b+1)*DIV];
         for (int c = 1; c < DIV; c++)
            if (line_hist[s+(b+1)*DIV+c] != got[b]) stable = 1'b0;
      end
      check({name, "_start"}, start_ok, 1);
      check({name, "_data"}, {stable, got}, {1'b1, exp});
      check({name, "_stop"}, stop_ok, 1);
   endtask

   // Decode every frame on the recorded line between two idle points.
   task automatic scan_frames(input int from, input int to);
      int i = from;
      scan_q.delete();
      while (i <= to) begin
         if (line_hist[i] == 1'b0) begin
            logic [7:0] b;
            for (int k = 0; k < 8; k++) b[k] = line_hist[i+(k+1)*DIV+DIV/2];
            scan_q.push_back(b);
            i += FRAME;
         end else begin
            i++;
         end
      end
   endtask

   task automatic compare_scan(input string name);
      check({name, "_count"}, scan_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < scan_q.size(); i++)
         check($sformatf("%s_byte%0d", name, i), scan_q[i], exp_q[i]);
   endtask

   initial begin
      #1_000_000;
      failures++;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w;
      int base;
      bit all_high;
      bit r_wr;
      logic [31:0] r_addr;
      logic [31:0] r_wd;
      logic [7:0] sent[$];

      vecs[0]  = '{1'b1, A_OTHER,       32'h0000_0011, 32'h000, 1'b1};
      vecs[1]  = '{1'b0, A_DATA,        32'h0,         32'h000, 1'b1};
      vecs[2]  = '{1'b1, A_DATA,        32'h0000_0001, 32'h200, 1'b1};
      vecs[3]  = '{1'b1, A_DATA,        32'h0000_0002, 32'h200, 1'b0};
      vecs[4]  = '{1'b1, A_DATA,        32'h0000_0003, 32'h200, 1'b0};
      vecs[5]  = '{1'b1, A_DATA,        32'h0000_0004, 32'h200, 1'b0};
      vecs[6]  = '{1'b1, A_DATA,        32'h0000_0005, 32'h300, 1'b0};
      vecs[7]  = '{1'b1, A_DATA,        32'h0000_0006, 32'h700, 1'b1};
      vecs[8]  = '{1'b1, A_DATA,        32'h8000_0000, 32'h300, 1'b1};
      vecs[9]  = '{1'b1, A_OTHER,       32'h0000_0099, 32'h000, 1'b1};
      vecs[10] = '{1'b0, A_DATA,        32'h0,         32'h300, 1'b1};
      vecs[11] = '{1'b0, 32'h0040_000C, 32'h0,         32'h300, 1'b0};

      // Reset state.
      RESET            = 1'b1;
      bus.IO_mem_wr    = 1'b0;
      bus.IO_mem_addr  = A_DATA;
      bus.IO_mem_wdata = 32'h0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_line", uart_tx, 1);
      check("rst_busy", tx_busy, 0);
      check("rst_status", bus.IO_mem_rdata, 32'h0);
      RESET = 1'b0;

      // Single byte 0x55.
      w = edge_cnt;
      step(1'b1, A_DATA, 32'h55);
      repeat (3) step(1'b0, A_DATA, 32'h0);
      check("single_status_busy", bus.IO_mem_rdata, 32'h200);
      while (edge_cnt < w + 45) step(1'b0, A_DATA, 32'h0);
      check("single_idle_at_write", line_hist[w], 1);
      check_frame("single", w + 1, 8'h55);
      check("single_busy_rise", busy_hist[w], 1);
      check("single_busy_last", busy_hist[w+40], 1);
      check("single_busy_fall", busy_hist[w+41], 0);
      check("idle_status", bus.IO_mem_rdata, 32'h0);

      // Back-to-back frames.
      w = edge_cnt;
      step(1'b1, A_DATA, 32'h41);
      step(1'b1, A_DATA, 32'h42);
      step(1'b1, A_DATA, 32'h43);
      while (edge_cnt < w + 125) step(1'b0, A_DATA, 32'h0);
      check_frame("b2b0", w + 1,  8'h41);
      check_frame("b2b1", w + 41, 8'h42);
      check_frame("b2b2", w + 81, 8'h43);
      check("b2b_busy_last", busy_hist[w+120], 1);
      check("b2b_busy_fall", busy_hist[w+121], 0);

      // Full / overflow / decode vector table.
      drain();
      base = edge_cnt;
      for (int i = 0; i < 12; i++) begin
         step(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
         check($sformatf("vec%0d_rdata", i), bus.IO_mem_rdata, vecs[i].exp_rdata);
         check($sformatf("vec%0d_tx", i), uart_tx, vecs[i].exp_tx);
      end
      drain();
      scan_frames(base, edge_cnt - 1);
      exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      compare_scan("overflow_frames");

      // Reset in the middle of data bit 3, with a second byte queued.
      w = edge_cnt;
      step(1'b1, A_DATA, 32'hF0);
      step(1'b1, A_DATA, 32'h33);
      while (edge_cnt < w + 19) step(1'b0, A_DATA, 32'h0);
      check("pre_reset_line", uart_tx, 0);
      #2;
      RESET = 1'b1;
      #1;
      check("async_rst_line", uart_tx, 1);
      check("async_rst_busy", tx_busy, 0);
      check("async_rst_status", bus.IO_mem_rdata, 32'h0);
      @(posedge clk);
      #1;
      line_hist[edge_cnt] = uart_tx;
      busy_hist[edge_cnt] = tx_busy;
      check("held_rst_line", uart_tx, 1);
      edge_cnt++;
      RESET = 1'b0;
      model_reset();
      w = edge_cnt;
      step(1'b1, A_DATA, 32'hA5);
      while (edge_cnt < w + 50) step(1'b0, A_DATA, 32'h0);
      check("post_rst_idle_at_write", line_hist[w], 1);
      check_frame("post_rst", w + 1, 8'hA5);
      check("post_rst_busy_fall", busy_hist[w+41], 0);
      all_high = 1'b1;
      for (int c = w + 41; c < edge_cnt; c++) if (line_hist[c] != 1'b1) all_high = 1'b0;
      check("post_rst_fifo_discarded", all_high, 1);

      // Wrap-around: ten bytes in bursts of 4, 3, 3.
      drain();
      base = edge_cnt;
      sent.delete();
      for (int b = 0; b < 3; b++) begin
         for (int j = 0; j < ((b == 0) ? 4 : 3); j++) begin
            r_wd = {24'h0, 8'($urandom)};
            sent.push_back(r_wd[7:0]);
            step(1'b1, A_DATA, r_wd);
         end
         drain();
      end
      scan_frames(base, edge_cnt - 1);
      exp_q = sent;
      compare_scan("wrap");

      // Randomized traffic, including decode misses, drops and flag clears.
      drain();
      base = edge_cnt;
      m_accepted.delete();
      for (int i = 0; i < 600; i++) begin
         r_wr      = ($urandom_range(0, 99) < 12);
         r_addr    = $urandom;
         r_addr[3] = ($urandom_range(0, 9) != 0);
         r_wd      = $urandom;
         r_wd[31]  = ($urandom_range(0, 19) == 0);
         step(r_wr, r_addr, r_wd);
      end
      drain();
      scan_frames(base, edge_cnt - 1);
      exp_q = m_accepted;
      compare_scan("random");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Memory-mapped UART transmitter peripheral on the core's IO bus, downstream of the memory stage's IO write port. It decodes IO writes to the UART data word (IO word-address bit 1), buffers bytes in a FIFO, and serialises them 8N1, LSB first, on `uart_tx`. It returns a status word combinationally on `IO_mem_rdata`, so firmware can poll busy/full before writing.

## Interface
- `CLK_FREQ_HZ`, default 27_000_000: clock frequency.
- `BAUD`, default 115200: line rate.
- `DEPTH`, default 16: FIFO entries; power of two, ≥2.
- `clk`  in  1  single clock; all state updates on posedge.
- `RESET`  in  1  asynchronous, active-high reset.
- `IO_mem_addr`  in  32  IO byte address from the core.
- `IO_mem_wdata`  in  32  IO write data.
- `IO_mem_wr`  in  1  IO write strobe, one cycle per store.
- `IO_mem_rdata`  out  32  status read data, combinational from address and registered state.
- `uart_tx`  out  1  serial line, registered, idle high.
- `tx_busy`  out  1  registered; 1 while the FIFO is non-empty or the FSM is not IDLE.

## Operation
- Decode: `sel = IO_mem_addr[3]`, which is word-address bit 1. Other address bits are ignored.
- Write, with `IO_mem_wr & sel`:
  - If `wdata[31]=1`: clear the `overflow` flag; push nothing.
  - Else if `count < DEPTH` (pre-edge value): push `wdata[7:0]`.
  - Else: drop the byte and set `overflow` (sticky).
- Read: `IO_mem_rdata = sel ? {21'b0, overflow, tx_busy, full, 8'b0} : 32'b0`.
  - `full = (count == DEPTH)`.
  - Bit 9 is busy, matching the firmware putchar poll.
- FIFO:
  - Circular buffer with `log2(DEPTH)`-bit read and write pointers that wrap modulo DEPTH.
  - `count` is `log2(DEPTH)+1` bits.
  - Push and pop in the same cycle leave `count` unchanged.
  - A push when full is rejected even if a pop happens in the same cycle.
- Baud timing:
  - `DIV = max(1, CLK_FREQ_HZ / BAUD)`, using integer truncation.
  - Each line bit lasts exactly DIV cycles.
  - The baud counter is reloaded on every state/bit change; there is no free-running phase.
- FSM states:
  - IDLE: `uart_tx=1`. If `count>0`, pop the head into the 8-bit shifter, go to START, load the counter with DIV-1.
  - START: `uart_tx=0` for DIV cycles, then go to DATA with `bit_idx=0`.
  - DATA: `uart_tx=shifter[0]`. Every DIV cycles, shift right and increment `bit_idx`. After bit 7 completes, go to STOP.
  - STOP: `uart_tx=1` for DIV cycles. At the end, if `count>0`, pop and go directly to START with no idle gap; else go to IDLE.
- Reset (asynchronous, also mid-frame):
  - `uart_tx=1`, `tx_busy=0`, FSM IDLE, pointers/count 0, `overflow=0`.
  - `IO_mem_rdata` reads 0 status bits.
  - The frame in progress is abandoned; FIFO contents are discarded.
  - Behaviour resumes on the first edge after RESET deasserts.

## Timing
- A write sampled at edge k is visible in `count` after edge k.
  - If the FSM was IDLE, the pop and START happen at edge k+1.
  - `uart_tx` falls right after edge k+1, so write-to-start-bit latency is 2 cycles.
- Frame length is 10·DIV cycles, start edge to start edge, when back-to-back.
- `tx_busy` rises after edge k, i.e. the cycle after the write.
  - It falls after the edge that ends STOP with the FIFO empty.
- A push and pop in the same cycle (STOP end or IDLE pop coinciding with a write) are both honoured.
- `IO_mem_rdata` reflects state registered at the previous edge. The core samples it in the same cycle it presents the address.
- No output depends combinationally on `IO_mem_wr`.

## Test plan
Bench settings: `CLK_FREQ_HZ=1000`, `BAUD=250`, so `DIV=4`; `DEPTH=4`.
- Single byte: write 0x55 at edge 0. `uart_tx` must be:
  - low for cycles 1–4 (start bit);
  - 1,0,1,0,1,0,1,0 with 4 cycles each (data bits);
  - high for 4 cycles (stop bit).
  - `tx_busy` falls after edge 41.
- Back-to-back: write 0x41, 0x42, 0x43 on consecutive cycles. The start bits are exactly 40 cycles apart with no idle gap. The decoded bytes are 0x41, 0x42, 0x43 in order.
- Full/overflow:
  - Write 6 bytes in 6 consecutive cycles. The first byte pops at edge 1, so 5 bytes are accepted and the 6th is dropped.
  - The status read shows bit 8 = 1 while `count=4`, and bit 10 = 1 after the drop.
  - Writing `0x8000_0000` clears bit 10 without changing `count`.
- Decode: a write with `IO_mem_addr=0x0040_0004` (bit 3 = 0) leaves `uart_tx` and `count` unchanged. A read at `0x0040_0008` returns `0x200` while busy and 0 when idle.
- Reset mid-frame: assert RESET during DATA bit 3.
  - `uart_tx` goes to 1 immediately, without waiting for a clock edge; `tx_busy` goes to 0.
  - After release, a new write of 0xA5 produces a clean frame starting 2 cycles later.
- Wrap-around: push and drain 10 bytes in three bursts. The pointers wrap past DEPTH and the output byte order is preserved.
